// File: rtl/dff_pkg.sv
// ----------------------------------------------------------------------------
// dff_pkg
//
// Shared definitions for the storage cells of the memory project.
//
// Contents:
//   DffWidthDefault - default word width of a d_flip_flop_cell (1 bit)
//   dff_word_t      - default-width data word held by register/array cells
//   dff_invert      - per-bit complement helper used for the NQ output
// ----------------------------------------------------------------------------
package dff_pkg;

    localparam int unsigned DffWidthDefault = 1;

    typedef logic [DffWidthDefault-1:0] dff_word_t;

    // Complement of a default-width word; wider cells invert in place.
    function automatic dff_word_t dff_invert(input dff_word_t word);
        return ~word;
    endfunction

endpackage

// File: rtl/d_flip_flop_cell_if.sv
// ----------------------------------------------------------------------------
// d_flip_flop_cell_if
//
// Data bundle of one d_flip_flop_cell.
//
// Signals:
//   d   - data in, WIDTH bits
//   en  - clock enable (only with DFF_CLOCK_ENABLE_EN defined)
//   q   - stored data, WIDTH bits
//   nq  - bitwise complement of q, WIDTH bits
//
// Modports:
//   master - the user of the cell: drives d (and en), observes q/nq
//   slave  - the cell itself: samples d (and en), drives q/nq
//
// Configuration macro: DFF_CLOCK_ENABLE_EN adds the en signal.
// ----------------------------------------------------------------------------
interface d_flip_flop_cell_if #(
    parameter int unsigned WIDTH = dff_pkg::DffWidthDefault
);
    import dff_pkg::*;

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
`ifdef DFF_CLOCK_ENABLE_EN
    logic             en;

    modport master (
        output d,
        output en,
        input  q,
        input  nq
    );

    modport slave (
        input  d,
        input  en,
        output q,
        output nq
    );
`else
    modport master (
        output d,
        input  q,
        input  nq
    );

    modport slave (
        input  d,
        output q,
        output nq
    );
`endif

endinterface

// File: rtl/d_latch.sv
// ----------------------------------------------------------------------------
// d_latch
//
// Level-sensitive D latch, WIDTH bits, with asynchronous active-low reset.
// Half of the master-slave pair inside d_flip_flop_cell.
//
// Parameters:
//   WIDTH       - number of bits held
//   RESET_VALUE - value forced onto q while rst_n is low
//
// Ports:
//   gate  - transparent while 1, holds while 0
//   data  - data in
//   rst_n - asynchronous active-low reset, dominates gate
//   q     - latched data
// ----------------------------------------------------------------------------
module d_latch #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             gate,
    input  logic [WIDTH-1:0] data,
    input  logic             rst_n,
    output logic [WIDTH-1:0] q
);

    always_latch begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (gate) begin
            q <= data;
        end
    end

endmodule

// File: rtl/d_flip_flop_cell.sv
// ----------------------------------------------------------------------------
// d_flip_flop_cell
//
// Positive-edge-triggered D flip-flop, WIDTH bits, with complementary outputs.
// Built as a master-slave pair of d_latch instances:
//   master - transparent while clk = 0, so it tracks d through the low phase
//   slave  - transparent while clk = 1, so it shows what the master froze at
//            the rising edge
// q therefore takes the value d had just before each rising edge and holds
// it until the next one; falling edges and d activity during the high phase
// never reach q.
//
// Parameters:
//   WIDTH       - number of stored bits (default dff_pkg::DffWidthDefault)
//   RESET_VALUE - value loaded into q by reset
//
// Ports:
//   clk   - clock, data captured on the rising edge
//   rst_n - asynchronous active-low reset; forces both latches to
//           RESET_VALUE immediately, clock edges ignored while low
//   bus   - d_flip_flop_cell_if.slave: d (and en) in, q/nq out
//
// Configuration macro: DFF_CLOCK_ENABLE_EN
//   defined   - bus.en gates capture; with en = 0 the master reloads q, so a
//               rising edge leaves q unchanged. Reset still overrides en.
//   undefined - every rising edge captures d.
// ----------------------------------------------------------------------------
module d_flip_flop_cell #(
    parameter int unsigned      WIDTH       = dff_pkg::DffWidthDefault,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    d_flip_flop_cell_if.slave      bus
);
    import dff_pkg::*;

    logic             clk_n;
    logic [WIDTH-1:0] master_d;
    logic [WIDTH-1:0] master_q;
    logic [WIDTH-1:0] slave_q;

    assign clk_n = ~clk;

`ifdef DFF_CLOCK_ENABLE_EN
    // Feeding q back while disabled makes the next edge a no-op. slave_q is
    // stable whenever the master is open (clk = 0), so this path never loops.
    assign master_d = bus.en ? bus.d : slave_q;
`else
    assign master_d = bus.d;
`endif

    d_latch #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_master (
        .gate  (clk_n),
        .data  (master_d),
        .rst_n (rst_n),
        .q     (master_q)
    );

    // A reset released coincident with a rising edge lets the slave open on
    // a master that is still holding RESET_VALUE, so that edge captures
    // nothing new.
    d_latch #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_slave (
        .gate  (clk),
        .data  (master_q),
        .rst_n (rst_n),
        .q     (slave_q)
    );

    // Both outputs come from the same source so they change in the same delta.
    assign bus.q  = slave_q;
    assign bus.nq = ~slave_q;

endmodule

// File: tb/tb_d_flip_flop_cell.sv
// ----------------------------------------------------------------------------
// tb_d_flip_flop_cell
//
// Directed bench for d_flip_flop_cell. Three cells share one 20 ns clock
// (low at t=0, rising edges at 10, 30, 50 ns ...):
//   dut0 - WIDTH 1, RESET_VALUE 0
//   dut1 - WIDTH 1, RESET_VALUE 1
//   dut8 - WIDTH 8, RESET_VALUE 0
// Inputs change only in the low phase or mid high phase, never at a rising
// edge (except rst_n in the deliberate release-at-edge sequence).
// ----------------------------------------------------------------------------
module tb_d_flip_flop_cell;

    typedef struct {
        logic [7:0] d;
        logic [7:0] q;
        logic [7:0] nq;
    } vec_t;

    logic clk;
    logic rst_n0;
    logic rst_n1;
    logic rst_n8;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t cap_tbl  [6];
    vec_t wide_tbl [4];

    d_flip_flop_cell_if #(.WIDTH(1)) bus0 ();
    d_flip_flop_cell_if #(.WIDTH(1)) bus1 ();
    d_flip_flop_cell_if #(.WIDTH(8)) bus8 ();

    d_flip_flop_cell #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (bus0)
    );

    d_flip_flop_cell #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1)
    );

    d_flip_flop_cell #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut8 (
        .clk   (clk),
        .rst_n (rst_n8),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Nothing here waits on a DUT event, but keep the run bounded regardless.
    initial begin
        #20000;
        $display("FAIL watchdog: run did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n0  = 1'b0;
        rst_n1  = 1'b0;
        rst_n8  = 1'b0;
        bus0.d  = 1'b1;
        bus1.d  = 1'b1;
        bus8.d  = 8'hFF;
`ifdef DFF_CLOCK_ENABLE_EN
        bus0.en = 1'b1;
        bus1.en = 1'b1;
        bus8.en = 1'b1;
`endif

        cap_tbl[0] = '{8'h00, 8'h00, 8'h01};
        cap_tbl[1] = '{8'h00, 8'h00, 8'h01};
        cap_tbl[2] = '{8'h01, 8'h01, 8'h00};
        cap_tbl[3] = '{8'h01, 8'h01, 8'h00};
        cap_tbl[4] = '{8'h01, 8'h01, 8'h00};
        cap_tbl[5] = '{8'h00, 8'h00, 8'h01};

        wide_tbl[0] = '{8'hA5, 8'hA5, 8'h5A};
        wide_tbl[1] = '{8'h3C, 8'h3C, 8'hC3};
        wide_tbl[2] = '{8'hFF, 8'hFF, 8'h00};
        wide_tbl[3] = '{8'h00, 8'h00, 8'hFF};

        // Reset state with d = 1, before any edge (t = 5).
        #5;
        check("rst_q0",  8'(bus0.q),  8'h00);
        check("rst_nq0", 8'(bus0.nq), 8'h01);
        check("rst_q1",  8'(bus1.q),  8'h01);
        check("rst_nq1", 8'(bus1.nq), 8'h00);
        check("rst_q8",  bus8.q,      8'h00);
        check("rst_nq8", bus8.nq,     8'hFF);

        // Rising edge at 10 ns is ignored while in reset (t = 15).
        #10;
        check("rst_edge_q0",  8'(bus0.q),  8'h00);
        check("rst_edge_nq0", 8'(bus0.nq), 8'h01);
        check("rst_edge_q1",  8'(bus1.q),  8'h01);
        check("rst_edge_nq1", 8'(bus1.nq), 8'h00);

        // Release mid low phase (t = 25); first capture is the edge at 30 ns.
        #10;
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        rst_n8 = 1'b1;

        // Capture sequence 0,0,1,1,1,0 with hold check across each fall.
        for (int i = 0; i < 6; i++) begin
            bus0.d = cap_tbl[i].d[0];
            @(posedge clk);
            #2;
            check("cap_q",  8'(bus0.q),  cap_tbl[i].q);
            check("cap_nq", 8'(bus0.nq), cap_tbl[i].nq);
            @(negedge clk);
            #1;
            check("cap_hold_q", 8'(bus0.q), cap_tbl[i].q);
        end

        // Glitch on d inside one high phase; q is 0 and must stay 0.
        @(posedge clk);
        #3 bus0.d = 1'b1;
        #3 bus0.d = 1'b0;
        @(negedge clk);
        #1;
        check("glitch_high_q", 8'(bus0.q), 8'h00);

        // d pulses high only in the low phase, back to 0 before the edge.
        #2 bus0.d = 1'b1;
        #3 bus0.d = 1'b0;
        @(posedge clk);
        #2;
        check("glitch_low_q", 8'(bus0.q), 8'h00);

        // Mid-operation reset between edges.
        @(negedge clk);
        bus0.d = 1'b1;
        @(posedge clk);
        #2;
        check("pre_reset_q", 8'(bus0.q), 8'h01);
        #3 rst_n0 = 1'b0;
        #1;
        check("async_reset_q",  8'(bus0.q),  8'h00);
        check("async_reset_nq", 8'(bus0.nq), 8'h01);
        @(posedge clk);
        #2;
        check("edge_in_reset_q", 8'(bus0.q), 8'h00);
        @(negedge clk);
        #5 rst_n0 = 1'b1;
        #1;
        check("released_hold_q", 8'(bus0.q), 8'h00);
        @(posedge clk);
        #2;
        check("capture_resumes_q", 8'(bus0.q), 8'h01);

        // Release coincident with a rising edge: that edge captures nothing.
        @(negedge clk);
        rst_n0 = 1'b0;
        #1;
        check("rst_again_q", 8'(bus0.q), 8'h00);
        @(posedge clk);
        rst_n0 = 1'b1;
        #2;
        check("release_at_edge_q",  8'(bus0.q),  8'h00);
        check("release_at_edge_nq", 8'(bus0.nq), 8'h01);
        @(posedge clk);
        #2;
        check("first_capture_q", 8'(bus0.q), 8'h01);

        // Wide word on dut8, bit 0 of each word also driven through dut1.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus8.d = wide_tbl[i].d;
            bus1.d = wide_tbl[i].d[0];
            @(posedge clk);
            #2;
            check("wide_q",  bus8.q,      wide_tbl[i].q);
            check("wide_nq", bus8.nq,     wide_tbl[i].nq);
            check("rv1_q",   8'(bus1.q),  {7'b0, wide_tbl[i].q[0]});
        end

`ifdef DFF_CLOCK_ENABLE_EN
        // dut0 holds 1; disabled edges must keep it, enabled edge loads 0.
        @(negedge clk);
        bus0.en = 1'b0;
        bus0.d  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("en_off_q", 8'(bus0.q), 8'h01);
        end
        @(negedge clk);
        bus0.en = 1'b1;
        @(posedge clk);
        #2;
        check("en_on_q",  8'(bus0.q),  8'h00);
        check("en_on_nq", 8'(bus0.nq), 8'h01);

        // Reset overrides a low enable: dut1 (now 0) jumps to its RESET_VALUE.
        @(negedge clk);
        bus1.en = 1'b0;
        rst_n1  = 1'b0;
        #1;
        check("rst_over_en_q", 8'(bus1.q), 8'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
